float_result_buffer: RTL
========================

# float_result_buffer

Downstream stage for the pipelined floating-point multiplier wrapper (fixed latency, no stall input, `done` pulse marks a valid result). It captures each completed product and its 5-bit exception flags into a small FIFO and re-presents them on a valid/ready stream. It issues credits upstream so the producer never launches an operation without a guaranteed landing slot. It also accumulates sticky exception flags across a run.

## Interface
- `expWidth`, 8: exponent width of the standard-format operand.
- `sigWidth`, 24: significand width including the hidden bit; data width W = expWidth+sigWidth.
- `DEPTH`, 4: FIFO entries, ≥2; need not be a power of two.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `issue`  in  1  the producer launched an operation this cycle; mirrors the multiplier's `val`.
- `in_done`  in  1  the multiplier result is valid this cycle.
- `in_data`  in  W  multiplier result, standard format.
- `in_flags`  in  5  result exception flags {invalid, infinite, overflow, underflow, inexact}.
- `can_issue`  out  1  high when a new `issue` is permitted.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  W  head entry data.
- `out_flags`  out  5  head entry flags.
- `clear_flags`  in  1  clears `sticky_flags` and `overrun`.
- `sticky_flags`  out  5  OR of the flags of every accepted result since the last clear.
- `overrun`  out  1  sticky: a result arrived with no free slot and was dropped.

## Operation
- State: FIFO storage with read pointer, write pointer, `count` (0..DEPTH), and `inflight` (0..DEPTH), which counts issued operations not yet returned. Counter width is $clog2(DEPTH+1).
- Push: an entry {in_data, in_flags} is written when `in_done` is high and (count<DEPTH or a pop occurs in the same cycle).
- Pop: occurs when `out_valid && out_ready`.
- Pointers wrap from DEPTH-1 to 0.
- `count` next value = count + push − pop.
- `inflight` next value = inflight + issue − in_done.
  - It saturates at DEPTH and floors at 0.
  - Issuing while `can_issue`=0, or a stray `in_done` with inflight=0, is a protocol error. No flag is raised for it; saturation or floor applies.
- `can_issue` = (count + inflight) < DEPTH. This is combinational from registered state only and never depends on same-cycle `issue` or `out_ready`.
- Drop: if `in_done` arrives while count=DEPTH and no pop occurs, the data is discarded and `overrun` is set. `inflight` still decrements.
- `sticky_flags` is ORed with `in_flags` on every push. Dropped results do not contribute.
- `clear_flags` zeroes `sticky_flags` and `overrun`. If a push or drop occurs in the same cycle, the new contribution wins: the result is that cycle's flags only, or overrun=1.
- `out_data`/`out_flags` hold the head entry while out_valid=1. Their value is don't-care when out_valid=0.

## Timing
- Reset values:
  - out_valid=0, count=0, inflight=0, can_issue=1.
  - sticky_flags=0, overrun=0.
  - Pointers 0. out_data/out_flags are driven 0.
  - Reset mid-operation discards all entries and credits. Results arriving after reset are counted against inflight=0 (floor), which is a protocol error.
- Push-to-visible latency is 1 cycle: with the FIFO empty, `in_done` at edge N gives out_valid=1 after edge N. There is no fall-through.
- Pop at edge N: the next entry, or out_valid=0, is visible after edge N.
- Full with simultaneous push and pop: both succeed and count stays at DEPTH.
- Empty with push and `out_ready`=1: no pop, because out_valid=0.
- The credit rule guarantees no drop when the producer obeys `can_issue` for any fixed multiplier latency.

## Configuration
- `FLOAT_RESULT_STICKY_FLAGS_EN` defined: the sticky accumulation and `clear_flags` logic are present as described.
- Not defined: `sticky_flags` is tied to 0, `clear_flags` is ignored, and the flag registers are removed. `overrun` remains, but it is cleared only by `reset`.
- Per-entry `out_flags` are unaffected in both cases.

## Structure
- Package `float_buf_pkg` holds:
  - Flag bit index constants: FLAG_INVALID=4, FLAG_INFINITE=3, FLAG_OVERFLOW=2, FLAG_UNDERFLOW=1, FLAG_INEXACT=0.
  - The flag-vector width constant, 5.
  - A parameterizable helper for the entry width (W+5).
- Sub-module `float_buf_fifo` provides generic width/depth storage, pointers, count, and push/pop. The top level holds the credit counter, drop detection and sticky logic.

## Test plan
Configuration for all scenarios: expWidth=8, sigWidth=24, DEPTH=4.
- Reset: assert `reset` 2 cycles → out_valid=0, can_issue=1, sticky_flags=0, overrun=0.
- Single pass: issue 1; 4 cycles later in_done with 32'h40C00000 and flags 5'b00001 → the next cycle shows out_valid=1, out_data=32'h40C00000, out_flags=5'b00001, sticky_flags=5'b00001.
- Credits: out_ready=0; issue 4 back-to-back → can_issue=0 from the cycle after the 4th issue. After all 4 results land, can_issue stays 0 until one pop, then returns to 1.
- Full simultaneous push/pop: full FIFO, out_ready=1 and in_done together → count stays 4, the head advances, and data order is preserved.
- Overrun: full, out_ready=0, forced in_done with flags 5'b10000 → overrun=1, sticky_flags unchanged, FIFO contents unchanged. Then clear_flags → overrun=0.
- Clear collision: clear_flags and a push with flags 5'b00100 in the same cycle → sticky_flags=5'b00100. Repeat with the macro undefined → sticky_flags=0.

Source files
------------

// File: rtl/float_buf_pkg.sv
// float_buf_pkg: shared flag indices, flag width and entry-width helper for the result buffer
package float_buf_pkg;
    localparam int FLAG_W         = 5;
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_INFINITE  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int entry_width(input int w);
        return w + FLAG_W;
    endfunction
endpackage

// File: rtl/float_buf_fifo.sv
// float_buf_fifo: generic registered FIFO, any depth >= 2, no fall-through; push accepted when not full or popping
module float_buf_fifo #(
    parameter  int W     = 37,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [W-1:0]  wdata,
    output logic          valid,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          push,
    output logic          pop
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    assign valid = count != '0;
    assign pop   = valid && pop_req;
    assign push  = push_req && (count != FULL || pop);
    assign rdata = valid ? mem[rd_ptr] : '0;

    // storage write; contents need no reset since rdata is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // pointers wrap at DEPTH-1 and count tracks push minus pop
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/float_result_buffer.sv
// float_result_buffer: credit-managed result FIFO for the FP multiplier; optional FLOAT_RESULT_STICKY_FLAGS_EN adds sticky flags and clear
module float_result_buffer
    import float_buf_pkg::*;
#(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue,
    input  logic                         in_done,
    input  logic [expWidth+sigWidth-1:0] in_data,
    input  logic [FLAG_W-1:0]            in_flags,
    output logic                         can_issue,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [expWidth+sigWidth-1:0] out_data,
    output logic [FLAG_W-1:0]            out_flags,
    input  logic                         clear_flags,
    output logic [FLAG_W-1:0]            sticky_flags,
    output logic                         overrun
);
    localparam int W  = expWidth + sigWidth;
    localparam int EW = entry_width(W);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DMAX = CW'(DEPTH);

    logic [EW-1:0] rdata;
    logic [CW-1:0] count, inflight;
    logic          push, pop, drop;

    float_buf_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_req (in_done),
        .pop_req  (out_ready),
        .wdata    ({in_data, in_flags}),
        .valid    (out_valid),
        .rdata    (rdata),
        .count    (count),
        .push     (push),
        .pop      (pop)
    );

    assign out_data  = rdata[EW-1:FLAG_W];
    assign out_flags = rdata[FLAG_W-1:0];
    assign drop      = in_done && !push;
    assign can_issue = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);

    // outstanding-operation credits, saturating at DEPTH and flooring at 0 on protocol errors
    always_ff @(posedge clk) begin
        if (reset)
            inflight <= '0;
        else if (issue && !in_done)
            inflight <= inflight == DMAX ? DMAX : inflight + 1'b1;
        else if (!issue && in_done)
            inflight <= inflight == '0 ? '0 : inflight - 1'b1;
    end

`ifdef FLOAT_RESULT_STICKY_FLAGS_EN
    // sticky flags and overrun; a same-cycle push or drop wins over clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_flags <= '0;
            overrun      <= 1'b0;
        end else begin
            sticky_flags <= (clear_flags ? '0 : sticky_flags) | (push ? in_flags : '0);
            overrun      <= (clear_flags ? 1'b0 : overrun) | drop;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear_flags;
    assign sticky_flags = '0;

    // overrun is sticky until reset when flag clearing is not built in
    always_ff @(posedge clk) begin
        if (reset) overrun <= 1'b0;
        else if (drop) overrun <= 1'b1;
    end
`endif
endmodule
